word_byte_tx: RTL

//  Transmit side of the byte-stream link that feeds the word statistics checker.
//  - Buffers WORD_SIZE-bit words from an upstream valid/ready source.
//  - Emits them as one byte per clk, LSB byte first, aligned to a free-running slot counter.
//  - The receiver assembles words with its own free-running byte counter from reset, so

---
 rtl/word_byte_tx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/word_byte_tx.sv
// word_byte_tx: transmit side of the byte-stream link feeding the word
// statistics checker. Words from a valid/ready source are buffered in a small
// FIFO and serialised LSB byte first, one byte per clk. Byte 0 of every word
// is aligned to slot 0 of a free-running slot counter, so a receiver that
// counts bytes from reset frames words without any side-band.
//
// Build option WORD_BYTE_TX_PRBS_IDLE_EN: when defined, idle slots carry a
// PRBS-8 sequence (x^8+x^6+x^5+x^4+1, seed 8'hFF) instead of IDLE_BYTE.
module word_byte_tx #(
  parameter int          WORD_SIZE  = 32,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [7:0]  IDLE_BYTE  = 8'h00
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [WORD_SIZE-1:0]              s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic [7:0]                        tx_byte,
  output logic [$clog2(WORD_SIZE/8)-1:0]    tx_slot,
  output logic                              tx_sof,
  output logic                              tx_eof,
  output logic                              tx_active,
  output logic [15:0]                       words_sent
);

  localparam int BYTE_CNT = WORD_SIZE / 8;
  localparam int SLOT_W   = $clog2(BYTE_CNT);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BYTE_CNT - 1);
`ifdef WORD_BYTE_TX_PRBS_IDLE_EN
  localparam logic [7:0] FILLER_RST = 8'hFF;
`else
  localparam logic [7:0] FILLER_RST = IDLE_BYTE;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [WORD_SIZE-9:0]   sh_q, sh_d;
  logic [7:0]             byte_q, byte_d;
  logic                   sof_q, sof_d, eof_q, eof_d, active_q, active_d;
  logic [15:0]            words_q, words_d;

  logic [WORD_SIZE-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q;
  logic                   full, empty, push, pop;
  logic [WORD_SIZE-1:0]   head;

`ifdef WORD_BYTE_TX_PRBS_IDLE_EN
  logic [7:0]             lfsr_q, lfsr_d;
`endif

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = s_valid && !full;
  assign head    = mem_q[rd_ptr_q];
  assign slot_d  = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;

  assign s_ready    = !full;
  assign tx_byte    = byte_q;
  assign tx_slot    = slot_q;
  assign tx_sof     = sof_q;
  assign tx_eof     = eof_q;
  assign tx_active  = active_q;
  assign words_sent = words_q;

  // FIFO storage; contents need no reset because count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Next-state and output decode; a word only ever starts when slot 0 comes next.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    sh_d     = sh_q;
    byte_d   = byte_q;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    active_d = 1'b0;
    words_d  = words_q;
`ifdef WORD_BYTE_TX_PRBS_IDLE_EN
    lfsr_d   = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        if (slot_q == LAST_SLOT && !empty) begin
          pop      = 1'b1;
          byte_d   = head[7:0];
          sh_d     = head[WORD_SIZE-1:8];
          sof_d    = 1'b1;
          active_d = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (slot_q == LAST_SLOT) begin
          words_d = words_q + 16'd1;
          if (!empty) begin
            pop      = 1'b1;
            byte_d   = head[7:0];
            sh_d     = head[WORD_SIZE-1:8];
            sof_d    = 1'b1;
            active_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          byte_d   = sh_q[7:0];
          sh_d     = sh_q >> 8;
          active_d = 1'b1;
          eof_d    = (slot_d == LAST_SLOT);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!active_d) begin
`ifdef WORD_BYTE_TX_PRBS_IDLE_EN
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      byte_d = lfsr_d;
`else
      byte_d = IDLE_BYTE;
`endif
    end
  end

  // State, slot counter and registered link outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      sh_q     <= '0;
      byte_q   <= FILLER_RST;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      active_q <= 1'b0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      sh_q     <= sh_d;
      byte_q   <= byte_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      active_q <= active_d;
      words_q  <= words_d;
    end
  end

`ifdef WORD_BYTE_TX_PRBS_IDLE_EN
  // Filler LFSR; only steps when a filler byte goes out, so it holds during a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hFF;
    else        lfsr_q <= lfsr_d;
  end
`endif

endmodule
